sensor_responder: RTL and testbench

SENSOR_RESPONDER -- requirements
Module: sensor_responder

---
 rtl/sensor_responder_pkg.sv | 35 +++
 rtl/sensor_responder_crc8_gen.sv | 10 +
 rtl/sensor_responder.sv | 151 +++++++++++++++
 tb/tb_sensor_responder.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/sensor_responder_pkg.sv
// Shared definitions for the sensor node responder and the poller-side CRC checker.
package sensor_responder_pkg;

  // Responder FSM encodings; the numeric values are visible on the debug port.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_DECODE    = 3'd1,
    ST_SEND_DATA = 3'd2,
    ST_WAIT_DATA = 3'd3,
    ST_SEND_CRC  = 3'd4,
    ST_WAIT_CRC  = 3'd5
  } state_t;

  localparam logic [7:0] CRC_POLY      = 8'h07;
  localparam logic [7:0] ALARM_CODE    = 8'hFF;
  localparam logic [2:0] RECOVERY_ADDR = 3'd0;

  // Last wait-counter value before a byte whose busy flag never rose is taken as sent.
  localparam logic [1:0] TX_TIMEOUT_LAST = 2'd3;

  // CRC-8 over one byte: init 0x00, MSB first, no reflection, no final XOR.
  function automatic logic [7:0] crc8_byte(input logic [7:0] data);
    logic [7:0] c;
    c = data;
    for (int i = 32'sd0; i < 32'sd8; i++) begin
      if (c[7]) begin
        c = {c[6:0], 1'b0} ^ CRC_POLY;
      end else begin
        c = {c[6:0], 1'b0};
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/sensor_responder_crc8_gen.sv
// Combinational CRC-8 of a single byte, shared with the poller-side checker.
module crc8_gen (
  input  logic [7:0] data,
  output logic [7:0] crc
);
  import sensor_responder_pkg::*;

  assign crc = crc8_byte(data);

endmodule

// File: rtl/sensor_responder.sv
// Sensor node responder: answers a one-byte poll with payload then CRC-8,
// keeps a sticky alarm that a broadcast recovery command clears.
module sensor_responder #(
  parameter logic [2:0] NODE_ID = 3'd1
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [7:0] rx_dout,
  input  logic       rx_rdy,
  output logic       rx_rdy_clr,
  output logic [7:0] tx_din,
  output logic       tx_wr_en,
  input  logic       tx_busy,
  input  logic [7:0] sensor_value,
  input  logic       alarm_in,
  output logic       alarm_latched,
  output logic [2:0] state
);
  import sensor_responder_pkg::*;

  state_t     state_r, state_n;
  logic [7:0] req_r, req_n;
  logic [7:0] payload_r, payload_n;
  logic [7:0] crc_r, crc_n;
  logic [7:0] tx_din_r, tx_din_n;
  logic       tx_wr_en_r, tx_wr_en_n;
  logic       rx_rdy_clr_r, rx_rdy_clr_n;
  logic       alarm_r, alarm_n;
  logic       seen_busy_r, seen_busy_n;
  logic [1:0] wait_cnt_r, wait_cnt_n;
  logic [7:0] crc_s;
  logic       alarm_clr_s;
  logic       tx_done_s;
  logic       req_unused_s;

  // Upper request bits carry no meaning for this node.
  assign req_unused_s = ^req_r[7:3];

  crc8_gen u_crc8_gen (
    .data (payload_r),
    .crc  (crc_s)
  );

  // A byte is done once busy was seen and has dropped, or busy never rose in time.
  assign tx_done_s = seen_busy_r || (wait_cnt_r == TX_TIMEOUT_LAST);

  // Next-state and next-register values for the request/reply sequencer.
  always_comb begin
    state_n      = state_r;
    req_n        = req_r;
    payload_n    = payload_r;
    crc_n        = crc_r;
    tx_din_n     = tx_din_r;
    tx_wr_en_n   = 1'b0;
    rx_rdy_clr_n = 1'b0;
    seen_busy_n  = seen_busy_r;
    wait_cnt_n   = wait_cnt_r;
    alarm_clr_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (rx_rdy) begin
          req_n        = rx_dout;
          rx_rdy_clr_n = 1'b1;
          state_n      = ST_DECODE;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_DECODE: begin
        if (req_r[2:0] == RECOVERY_ADDR) begin
          alarm_clr_s = 1'b1;
          state_n     = ST_IDLE;
        end else if (req_r[2:0] == NODE_ID) begin
          payload_n = alarm_r ? ALARM_CODE : sensor_value;
          state_n   = ST_SEND_DATA;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_SEND_DATA, ST_SEND_CRC: begin
        if (!tx_busy) begin
          tx_din_n    = (state_r == ST_SEND_DATA) ? payload_r : crc_r;
          tx_wr_en_n  = 1'b1;
          crc_n       = (state_r == ST_SEND_DATA) ? crc_s : crc_r;
          seen_busy_n = 1'b0;
          wait_cnt_n  = 2'd0;
          state_n     = (state_r == ST_SEND_DATA) ? ST_WAIT_DATA : ST_WAIT_CRC;
        end else begin
          state_n = state_r;
        end
      end
      ST_WAIT_DATA, ST_WAIT_CRC: begin
        if (tx_busy) begin
          seen_busy_n = 1'b1;
        end else if (tx_done_s) begin
          state_n = (state_r == ST_WAIT_DATA) ? ST_SEND_CRC : ST_IDLE;
        end else begin
          wait_cnt_n = wait_cnt_r + 2'd1;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // Sticky alarm: a live alarm beats a recovery command in the same cycle.
  always_comb begin
    if (alarm_in) begin
      alarm_n = 1'b1;
    end else if (alarm_clr_s) begin
      alarm_n = 1'b0;
    end else begin
      alarm_n = alarm_r;
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_r      <= ST_IDLE;
      req_r        <= 8'h00;
      payload_r    <= 8'h00;
      crc_r        <= 8'h00;
      tx_din_r     <= 8'h00;
      tx_wr_en_r   <= 1'b0;
      rx_rdy_clr_r <= 1'b0;
      alarm_r      <= 1'b0;
      seen_busy_r  <= 1'b0;
      wait_cnt_r   <= 2'd0;
    end else begin
      state_r      <= state_n;
      req_r        <= req_n;
      payload_r    <= payload_n;
      crc_r        <= crc_n;
      tx_din_r     <= tx_din_n;
      tx_wr_en_r   <= tx_wr_en_n;
      rx_rdy_clr_r <= rx_rdy_clr_n;
      alarm_r      <= alarm_n;
      seen_busy_r  <= seen_busy_n;
      wait_cnt_r   <= wait_cnt_n;
    end
  end

  assign rx_rdy_clr    = rx_rdy_clr_r;
  assign tx_din        = tx_din_r;
  assign tx_wr_en      = tx_wr_en_r;
  assign alarm_latched = alarm_r;
  assign state         = state_r;

endmodule

// File: tb/tb_sensor_responder.sv
// Directed self-checking bench for sensor_responder (NODE_ID = 1).
module tb_sensor_responder;

  logic       clock = 1'b0;
  logic       resetn;
  logic [7:0] rx_dout;
  logic       rx_rdy;
  logic       rx_rdy_clr;
  logic [7:0] tx_din;
  logic       tx_wr_en;
  logic       tx_busy;
  logic [7:0] sensor_value;
  logic       alarm_in;
  logic       alarm_latched;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;
  int strobes = 0;
  int dbl_strobes = 0;
  logic prev_wr = 1'b0;
  logic [7:0] txq[$];

  int strobe_base;
  int q_base;
  logic found;

  always #10 clock = ~clock;

  sensor_responder #(.NODE_ID(3'd1)) dut (
    .clock         (clock),
    .resetn        (resetn),
    .rx_dout       (rx_dout),
    .rx_rdy        (rx_rdy),
    .rx_rdy_clr    (rx_rdy_clr),
    .tx_din        (tx_din),
    .tx_wr_en      (tx_wr_en),
    .tx_busy       (tx_busy),
    .sensor_value  (sensor_value),
    .alarm_in      (alarm_in),
    .alarm_latched (alarm_latched),
    .state         (state)
  );

  // Wire monitor: records every transmitted byte and flags back-to-back strobes.
  always @(negedge clock) begin
    if (tx_wr_en) begin
      strobes <= strobes + 1;
      txq.push_back(tx_din);
      if (prev_wr) dbl_strobes <= dbl_strobes + 1;
    end
    prev_wr <= tx_wr_en;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) @(negedge clock);
  endtask

  // Present a request byte; returns on the negedge where the clear pulse is seen.
  task automatic do_req(input logic [7:0] b);
    logic ok;
    ok = 1'b0;
    rx_dout = b;
    rx_rdy  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      if (rx_rdy_clr) begin
        ok = 1'b1;
        break;
      end
    end
    check("req_clr_seen", 32'(ok), 32'd1);
    rx_rdy = 1'b0;
  endtask

  task automatic wait_idle();
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clock);
      if (state == 3'd0) begin
        ok = 1'b1;
        break;
      end
    end
    check("idle_reached", 32'(ok), 32'd1);
  endtask

  task automatic mark();
    strobe_base = strobes;
    q_base      = txq.size();
  endtask

  task automatic expect_reply(input string tag, input logic [7:0] b0, input logic [7:0] b1);
    check({tag, "_strobes"}, 32'(strobes - strobe_base), 32'd2);
    if (txq.size() >= q_base + 2) begin
      check({tag, "_payload"}, 32'(txq[q_base]), 32'(b0));
      check({tag, "_crc"}, 32'(txq[q_base + 1]), 32'(b1));
    end else begin
      check({tag, "_bytes"}, 32'(txq.size() - q_base), 32'd2);
    end
  endtask

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    resetn = 1'b0; rx_rdy = 1'b0; rx_dout = 8'h00; tx_busy = 1'b0;
    sensor_value = 8'h01; alarm_in = 1'b0;
    step(3);
    check("rst_state", 32'(state), 32'd0);
    check("rst_clr", 32'(rx_rdy_clr), 32'd0);
    check("rst_wr", 32'(tx_wr_en), 32'd0);
    check("rst_din", 32'(tx_din), 32'h00);
    check("rst_alarm", 32'(alarm_latched), 32'd0);
    resetn = 1'b1;
    step(2);

    // Basic reply and 3-cycle latency.
    mark();
    do_req(8'h01);
    check("t1_decode", 32'(state), 32'd1);
    step(1);
    check("t1_send_state", 32'(state), 32'd2);
    check("t1_no_early_wr", 32'(tx_wr_en), 32'd0);
    step(1);
    check("t1_latency_wr", 32'(tx_wr_en), 32'd1);
    check("t1_latency_din", 32'(tx_din), 32'h01);
    wait_idle(); step(1);
    expect_reply("t1", 8'h01, 8'h07);

    // Alarm pulse, then alarm code reply.
    alarm_in = 1'b1; step(1); alarm_in = 1'b0; step(1);
    check("t2_alarm_set", 32'(alarm_latched), 32'd1);
    mark();
    do_req(8'h01);
    wait_idle(); step(1);
    expect_reply("t2", 8'hFF, 8'hF3);
    check("t2_alarm_sticky", 32'(alarm_latched), 32'd1);

    // Recovery command clears alarm silently.
    mark();
    do_req(8'h00);
    check("t3_alarm_in_decode", 32'(alarm_latched), 32'd1);
    step(1);
    check("t3_alarm_cleared", 32'(alarm_latched), 32'd0);
    check("t3_back_idle", 32'(state), 32'd0);
    step(12);
    check("t3_no_tx", 32'(strobes - strobe_base), 32'd0);

    // Alarm set coinciding with recovery: set wins.
    do_req(8'h00);
    alarm_in = 1'b1; step(1); alarm_in = 1'b0;
    check("t3b_set_wins", 32'(alarm_latched), 32'd1);
    do_req(8'h00); step(1);
    check("t3b_recovered", 32'(alarm_latched), 32'd0);

    // Foreign address ignored; upper bits ignored.
    sensor_value = 8'h5A;
    mark();
    do_req(8'h02);
    wait_idle(); step(12);
    check("t4_foreign_silent", 32'(strobes - strobe_base), 32'd0);
    mark();
    do_req(8'hF9);
    wait_idle(); step(1);
    expect_reply("t4_f9", 8'h5A, 8'h81);

    // Busy held 20 cycles before CRC byte; a new request stays pending meanwhile.
    mark();
    do_req(8'h01);
    step(2);
    check("t5_first_wr", 32'(tx_wr_en), 32'd1);
    tx_busy = 1'b1; rx_dout = 8'h03; rx_rdy = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(1);
      check("t5_busy_no_wr", 32'(tx_wr_en), 32'd0);
      check("t5_din_hold", 32'(tx_din), 32'h5A);
      check("t5_pending_no_clr", 32'(rx_rdy_clr), 32'd0);
    end
    tx_busy = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (tx_wr_en) begin found = 1'b1; break; end
    end
    check("t5_crc_strobe", 32'(found), 32'd1);
    check("t5_crc_byte", 32'(tx_din), 32'h81);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (rx_rdy_clr) begin found = 1'b1; break; end
    end
    check("t5_pending_serviced", 32'(found), 32'd1);
    rx_rdy = 1'b0;
    wait_idle(); step(12);
    expect_reply("t5", 8'h5A, 8'h81);

    // Reset during WAIT_DATA aborts the reply.
    alarm_in = 1'b1; step(1); alarm_in = 1'b0;
    mark();
    do_req(8'h01);
    step(2);
    check("t6_wait_data", 32'(state), 32'd3);
    resetn = 1'b0;
    step(1);
    check("t6_rst_state", 32'(state), 32'd0);
    check("t6_rst_wr", 32'(tx_wr_en), 32'd0);
    check("t6_rst_din", 32'(tx_din), 32'h00);
    check("t6_rst_clr", 32'(rx_rdy_clr), 32'd0);
    check("t6_rst_alarm", 32'(alarm_latched), 32'd0);
    step(2);
    resetn = 1'b1;
    step(12);
    check("t6_no_crc", 32'(strobes - strobe_base), 32'd1);
    mark();
    do_req(8'h01);
    wait_idle(); step(1);
    expect_reply("t6_after", 8'h5A, 8'h81);

    check("no_double_strobe", 32'(dbl_strobes), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
